// File: rtl/tristate_led_seq.sv
// tristate_led_seq: multi-channel LED brightness sequencer.
// Every channel cycles OFF / DIM / BRIGHT. A shared prescaler tick sets the
// dwell timing. The pads are driven through led_o/led_oe, and tri-state
// (DIM) is the middle brightness level.

// One LED channel: a 3-state FSM plus a dwell counter that advances on ticks.
module tristate_led_lane #(
  parameter int STEP_TICKS = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       dir,
  input  logic       force_i,
  input  logic [1:0] force_state,
  input  logic       tick,
  output logic [1:0] state_o,
  output logic       led_o,
  output logic       led_oe
);

  localparam int DW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(STEP_TICKS - 1);

  localparam logic [1:0] S_OFF    = 2'b00;
  localparam logic [1:0] S_DIM    = 2'b01;
  localparam logic [1:0] S_BRIGHT = 2'b10;
  localparam logic [1:0] S_ILL    = 2'b11;

  logic [1:0]    state_q, state_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic          force_ok;
  logic [1:0]    adv_state;

  // A force to the illegal code is treated as no force at all.
  assign force_ok = force_i && (force_state != S_ILL);

  // State and dwell registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_OFF;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
    end
  end

  // Successor state for the current direction. dir is read only here, so a
  // direction change takes effect at the next advance and leaves dwell alone.
  always_comb begin
    adv_state = S_OFF;
    unique case (state_q)
      S_OFF:    adv_state = dir ? S_BRIGHT : S_DIM;
      S_DIM:    adv_state = dir ? S_OFF    : S_BRIGHT;
      S_BRIGHT: adv_state = dir ? S_DIM    : S_OFF;
      default:  adv_state = S_OFF;
    endcase
  end

  // Next state, in priority order: force, illegal recovery, tick-driven dwell.
  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q;
    if (force_ok) begin
      state_d = force_state;
      dwell_d = '0;
    end else if (state_q == S_ILL) begin
      state_d = S_OFF;
      dwell_d = '0;
    end else if (run && tick) begin
      if (dwell_q == DWELL_LAST) begin
        state_d = adv_state;
        dwell_d = '0;
      end else begin
        dwell_d = dwell_q + DW'(1);
      end
    end
  end

  // Pad decode. The illegal code reads as OFF.
  always_comb begin
    led_o  = 1'b1;
    led_oe = 1'b1;
    unique case (state_q)
      S_DIM:    begin led_o = 1'b1; led_oe = 1'b0; end
      S_BRIGHT: begin led_o = 1'b0; led_oe = 1'b1; end
      default:  begin led_o = 1'b1; led_oe = 1'b1; end
    endcase
  end

  assign state_o = state_q;

endmodule

// Top level: one shared prescaler and CHANNELS independent lanes.
// The per-channel load strobe is named force_i because "force" is a keyword.
module tristate_led_seq #(
  parameter int CHANNELS   = 4,
  parameter int DIV        = 2560000,
  parameter int STEP_TICKS = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CHANNELS-1:0]   run,
  input  logic [CHANNELS-1:0]   dir,
  input  logic [CHANNELS-1:0]   force_i,
  input  logic [1:0]            force_state,
  output logic [CHANNELS-1:0]   led_o,
  output logic [CHANNELS-1:0]   led_oe,
  output logic [2*CHANNELS-1:0] state_o,
  output logic                  tick_o
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] CNT_LAST = PW'(DIV - 1);

  logic [PW-1:0] cnt_q, cnt_d;
  logic          tick;

  // The tick is decoded from the register. With DIV=1 the counter stays at 0,
  // so the tick is stuck high even while the block is in reset.
  assign tick   = (cnt_q == CNT_LAST);
  assign tick_o = tick;

  // Free-running prescaler. Compare-and-wrap keeps the count from overflowing.
  always_comb begin
    cnt_d = tick ? '0 : cnt_q + PW'(1);
  end

  // Prescaler register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    tristate_led_lane #(
      .STEP_TICKS (STEP_TICKS)
    ) u_lane (
      .clk         (clk),
      .rst_n       (rst_n),
      .run         (run[i]),
      .dir         (dir[i]),
      .force_i     (force_i[i]),
      .force_state (force_state),
      .tick        (tick),
      .state_o     (state_o[2*i +: 2]),
      .led_o       (led_o[i]),
      .led_oe      (led_oe[i])
    );
  end

endmodule

// File: tb/tb_tristate_led_seq.sv
// Bench for tristate_led_seq. A behavioural model works out each channel's
// state from edge count, tick spacing and a per-direction state ordering. The
// bench runs directed scenarios first and then a randomized phase.
module tb_tristate_led_seq;

  localparam int CH = 2;
  localparam int DV = 4;
  localparam int ST = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [CH-1:0]   run, dir, frc;
  logic [1:0]      fs;
  logic [CH-1:0]   led_o, led_oe;
  logic [2*CH-1:0] state_o;
  logic            tick_o;

  int ncomp = 0;
  int nfail = 0;

  // Model: edges since reset release, plus per-channel state and tick progress.
  int ecnt;
  int mst[CH];
  int mprog[CH];

  tristate_led_seq #(.CHANNELS(CH), .DIV(DV), .STEP_TICKS(ST)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .dir(dir), .force_i(frc),
    .force_state(fs), .led_o(led_o), .led_oe(led_oe), .state_o(state_o),
    .tick_o(tick_o)
  );

  always #5 clk = ~clk;

  function automatic int next_of(int s, bit d);
    int ord[3];
    if (d) ord = '{0, 2, 1};
    else   ord = '{0, 1, 2};
    for (int k = 0; k < 3; k++)
      if (ord[k] == s) return ord[(k + 1) % 3];
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ecnt = 0;
    for (int c = 0; c < CH; c++) begin
      mst[c]   = 0;
      mprog[c] = 0;
    end
  endtask

  // Applies one rising edge to the model, using the inputs that are present now.
  task automatic model_step();
    bit tk;
    tk = ((ecnt % DV) == DV - 1);
    for (int c = 0; c < CH; c++) begin
      if (frc[c] && fs != 2'b11) begin
        mst[c]   = int'(fs);
        mprog[c] = 0;
      end else if (mst[c] == 3) begin
        mst[c]   = 0;
        mprog[c] = 0;
      end else if (run[c] && tk) begin
        mprog[c]++;
        if (mprog[c] == ST) begin
          mst[c]   = next_of(mst[c], dir[c]);
          mprog[c] = 0;
        end
      end
    end
    ecnt++;
  endtask

  task automatic check_all(input string tag);
    logic [2*CH-1:0] es;
    logic [CH-1:0]   el, eo;
    for (int c = 0; c < CH; c++) begin
      es[2*c +: 2] = 2'(mst[c]);
      el[c] = (mst[c] == 2) ? 1'b0 : 1'b1;
      eo[c] = (mst[c] == 1) ? 1'b0 : 1'b1;
    end
    chk({tag, "/state"}, 32'(state_o), 32'(es));
    chk({tag, "/led"},   32'(led_o),   32'(el));
    chk({tag, "/oe"},    32'(led_oe),  32'(eo));
    chk({tag, "/tick"},  32'(tick_o),  32'((ecnt % DV) == DV - 1));
  endtask

  task automatic cyc(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    model_reset();
    check_all("reset");
    rst_n = 1'b1;
  endtask

  initial begin
    run = 2'b11; dir = 2'b00; frc = 2'b00; fs = 2'b00;
    rst_n = 1'b0;

    // Reset, then free run forward.
    do_reset();
    for (int i = 1; i <= 40; i++) begin
      cyc("free");
      if (i == 11) chk("free_e11", 32'(state_o), 32'h0);
      if (i == 12) chk("free_e12", 32'(state_o), 32'h5);
      if (i == 24) chk("free_e24", 32'(state_o), 32'hA);
      if (i == 36) chk("free_e36", 32'(state_o), 32'h0);
    end

    // Direction: channel 1 reversed.
    @(posedge clk); #1;
    dir = 2'b10;
    do_reset();
    for (int i = 1; i <= 40; i++) begin
      cyc("dir");
      if (i == 12) chk("dir_e12", 32'(state_o), 32'h9);
      if (i == 24) chk("dir_e24", 32'(state_o), 32'h6);
    end

    // Freeze channel 0 for 10 cycles in the middle of a step.
    dir = 2'b00;
    do_reset();
    for (int i = 0; i < 5; i++) cyc("frz_a");
    run = 2'b10;
    for (int i = 0; i < 10; i++) cyc("frz_b");
    run = 2'b11;
    for (int i = 0; i < 30; i++) cyc("frz_c");

    // A force on the would-be advance edge wins and restarts the dwell.
    do_reset();
    for (int i = 0; i < 11; i++) cyc("fp_a");
    frc = 2'b01; fs = 2'b10;
    cyc("fp_hit");
    chk("fp_bright", 32'(state_o[1:0]), 32'h2);
    frc = 2'b00;
    for (int i = 1; i <= 12; i++) begin
      cyc("fp_b");
      if (i == 11) chk("fp_hold", 32'(state_o[1:0]), 32'h2);
      if (i == 12) chk("fp_next", 32'(state_o[1:0]), 32'h0);
    end

    // A force to the illegal code is ignored.
    do_reset();
    for (int i = 0; i < 11; i++) cyc("fi_a");
    frc = 2'b01; fs = 2'b11;
    cyc("fi_hit");
    chk("fi_dim", 32'(state_o[1:0]), 32'h1);
    frc = 2'b00;
    for (int i = 0; i < 6; i++) cyc("fi_b");

    // Illegal state injected into channel 0 while it is BRIGHT.
    do_reset();
    for (int i = 0; i < 25; i++) cyc("il_a");
    force dut.g_lane[0].u_lane.state_q = 2'b11;
    mst[0] = 3;
    #1;
    check_all("il_inj");
    release dut.g_lane[0].u_lane.state_q;
    cyc("il_rec");
    chk("il_off", 32'(state_o[1:0]), 32'h0);
    for (int i = 0; i < 15; i++) cyc("il_b");

    // Asynchronous reset between edges while BRIGHT.
    do_reset();
    for (int i = 0; i < 25; i++) cyc("ar_a");
    chk("ar_pre", 32'(state_o[1:0]), 32'h2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_led",   32'(led_o),   32'h3);
    chk("ar_oe",    32'(led_oe),  32'h3);
    chk("ar_state", 32'(state_o), 32'h0);
    chk("ar_tick",  32'(tick_o),  32'h0);
    model_reset();
    #2;
    rst_n = 1'b1;
    for (int i = 1; i <= 13; i++) begin
      cyc("ar_b");
      if (i == 11) chk("ar_e11", 32'(state_o), 32'h0);
      if (i == 12) chk("ar_e12", 32'(state_o), 32'h5);
    end

    // Randomized run, dir, force and force_state.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      run = 2'($urandom_range(0, 3));
      dir = 2'($urandom_range(0, 3));
      frc = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      fs  = 2'($urandom_range(0, 3));
      cyc("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
